// File: rtl/hft_order_pkg.sv
// Order-word layout, type/side codes and transmit FSM encoding, shared with the matching engine.
package hft_order_pkg;

  localparam logic [1:0] ORD_LIMIT  = 2'b00;
  localparam logic [1:0] ORD_MARKET = 2'b01;
  localparam logic [1:0] ORD_STOP   = 2'b10;
  localparam logic [1:0] ORD_TRAIL  = 2'b11;

  localparam logic [1:0] SIDE_BUY  = 2'b00;
  localparam logic [1:0] SIDE_SELL = 2'b01;

  localparam int ORD_WORD_W    = 32;
  localparam int ORD_TYPE_MSB  = 31;
  localparam int ORD_TYPE_LSB  = 30;
  localparam int ORD_SIDE_MSB  = 29;
  localparam int ORD_SIDE_LSB  = 28;
  localparam int ORD_PRICE_MSB = 27;
  localparam int ORD_PRICE_LSB = 20;
  localparam int ORD_QTY_MSB   = 19;
  localparam int ORD_QTY_LSB   = 12;
  localparam int ORD_STOP_MSB  = 11;
  localparam int ORD_STOP_LSB  = 4;
  localparam int ORD_TRAIL_MSB = 3;
  localparam int ORD_TRAIL_LSB = 0;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/order_fifo.sv
// Synchronous FIFO with power-of-two depth; head is visible combinationally on pop_data.
module order_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/order_entry_packer.sv
// Validates and packs strategy orders, queues them, and strobes them to the engine with enforced spacing.
module order_entry_packer
  import hft_order_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_GAP    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  in_type,
  input  logic [1:0]  in_side,
  input  logic [7:0]  in_price,
  input  logic [7:0]  in_qty,
  input  logic [7:0]  in_stop,
  input  logic [3:0]  in_trail,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        enable,
  output logic [31:0] order_data,
  output logic        order_valid,
  output logic        reject_pulse,
  output logic [15:0] sent_count,
  output logic [15:0] reject_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);

  logic                  handshake;
  logic                  bad_order;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         unused_count;
  logic [ORD_WORD_W-1:0] packed_word;
  logic [ORD_WORD_W-1:0] head;
  tx_state_t             state;
  logic [GW-1:0]         gap_cnt;

  assign in_ready  = !full;
  assign handshake = in_valid && in_ready;
  assign bad_order = (in_qty == 8'd0) || in_side[1] ||
                     ((in_type == ORD_STOP || in_type == ORD_TRAIL) && in_stop == 8'd0);
  assign push      = handshake && !bad_order;
  assign pop       = (state == TX_IDLE) && !empty && enable;

  always_comb begin
    packed_word = '0;
    packed_word[ORD_TYPE_MSB:ORD_TYPE_LSB] = in_type;
    packed_word[ORD_SIDE_MSB:ORD_SIDE_LSB] = in_side;
    packed_word[ORD_QTY_MSB:ORD_QTY_LSB]   = in_qty;
    if (in_type != ORD_MARKET)
      packed_word[ORD_PRICE_MSB:ORD_PRICE_LSB] = in_price;
    if (in_type == ORD_STOP || in_type == ORD_TRAIL)
      packed_word[ORD_STOP_MSB:ORD_STOP_LSB] = in_stop;
    if (in_type == ORD_TRAIL)
      packed_word[ORD_TRAIL_MSB:ORD_TRAIL_LSB] = in_trail;
  end

  order_fifo #(
    .WIDTH (ORD_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (packed_word),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (unused_count)
  );

  // Engine has no backpressure: the pulse is emitted on leaving SEND, then MIN_GAP idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TX_IDLE;
      gap_cnt     <= '0;
      order_valid <= 1'b0;
      order_data  <= '0;
      sent_count  <= '0;
    end else begin
      order_valid <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (pop) begin
            order_data <= head;
            state      <= TX_SEND;
          end
        end
        TX_SEND: begin
          order_valid <= 1'b1;
          gap_cnt     <= GW'(MIN_GAP);
          sent_count  <= sent_count + 16'd1;
          state       <= TX_GAP;
        end
        TX_GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) state <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reject_pulse <= 1'b0;
      reject_count <= '0;
    end else begin
      reject_pulse <= handshake && bad_order;
      if (handshake && bad_order && reject_count != 16'hFFFF)
        reject_count <= reject_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_order_entry_packer.sv
// Directed and randomized checks of order_entry_packer against a queue-based timing model.
module tb_order_entry_packer;
  localparam int DEPTH = 8;
  localparam int GAP   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_type, in_side;
  logic [7:0]  in_price, in_qty, in_stop;
  logic [3:0]  in_trail;
  logic        in_valid, in_ready, enable;
  logic [31:0] order_data;
  logic        order_valid, reject_pulse;
  logic [15:0] sent_count, reject_count;

  always #5 clk = ~clk;

  order_entry_packer #(.FIFO_DEPTH(DEPTH), .MIN_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .in_type(in_type), .in_side(in_side), .in_price(in_price),
    .in_qty(in_qty), .in_stop(in_stop), .in_trail(in_trail), .in_valid(in_valid),
    .in_ready(in_ready), .enable(enable), .order_data(order_data), .order_valid(order_valid),
    .reject_pulse(reject_pulse), .sent_count(sent_count), .reject_count(reject_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: buffered words, one popped word awaiting its strobe, earliest next pop edge.
  logic [31:0] mq[$];
  logic [31:0] pend = '0;
  bit          pend_vld = 0;
  int          cyc = 0;
  int          next_pop = 0;
  int          exp_sent = 0;
  int          exp_rej = 0;
  bit          exp_pulse = 0;
  bit          exp_rp = 0;
  logic [31:0] exp_word = '0;

  int          n_pulses = 0;
  int          last_pulse_cyc = -1;
  logic [31:0] last_data = '0;
  int          pulse_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [1:0] t, input logic [1:0] s,
                                          input logic [7:0] p, input logic [7:0] q,
                                          input logic [7:0] st, input logic [3:0] tr);
    logic [7:0] p2;
    logic [7:0] st2;
    logic [3:0] tr2;
    p2  = (t == 2'b01) ? 8'h00 : p;
    st2 = (t == 2'b00 || t == 2'b01) ? 8'h00 : st;
    tr2 = (t == 2'b11) ? tr : 4'h0;
    return {t, s, p2, q, st2, tr2};
  endfunction

  function automatic bit is_bad(input logic [1:0] t, input logic [1:0] s,
                                input logic [7:0] q, input logic [7:0] st);
    return (q == 8'd0) || s[1] || (t[1] && st == 8'd0);
  endfunction

  task automatic tick();
    bit fire, rej, pop;
    logic [31:0] w;
    check("in_ready", in_ready, 32'(mq.size() < DEPTH));
    fire = !rst && in_valid && (mq.size() < DEPTH);
    rej  = fire && is_bad(in_type, in_side, in_qty, in_stop);
    pop  = !rst && enable && (mq.size() > 0) && (cyc + 1 >= next_pop);
    w    = word_of(in_type, in_side, in_price, in_qty, in_stop, in_trail);
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      pend_vld  = 0;
      exp_pulse = 0;
      exp_rp    = 0;
      exp_sent  = 0;
      exp_rej   = 0;
      next_pop  = 0;
    end else begin
      exp_pulse = pend_vld;
      exp_word  = pend;
      if (pend_vld) exp_sent = (exp_sent + 1) % 65536;
      pend_vld = 0;
      if (pop) begin
        pend     = mq.pop_front();
        pend_vld = 1;
        next_pop = cyc + GAP + 2;
      end
      if (fire && !rej) mq.push_back(w);
      exp_rp = rej;
      if (rej && exp_rej < 65535) exp_rej++;
    end
    #1;
    check("order_valid", order_valid, exp_pulse);
    if (exp_pulse) check("order_data", order_data, exp_word);
    check("reject_pulse", reject_pulse, exp_rp);
    check("sent_count", sent_count, exp_sent);
    check("reject_count", reject_count, exp_rej);
    if (order_valid) begin
      n_pulses++;
      last_pulse_cyc = cyc;
      last_data = order_data;
      pulse_cyc.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [1:0] t, input logic [1:0] s, input logic [7:0] p,
                      input logic [7:0] q, input logic [7:0] st, input logic [3:0] tr);
    in_type = t; in_side = s; in_price = p; in_qty = q; in_stop = st; in_trail = tr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_random_valid();
    send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 1)), 8'($urandom),
         8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 4'($urandom));
  endtask

  initial begin
    int hs, pb, first;
    rst = 1'b1; in_valid = 1'b0; enable = 1'b1;
    in_type = '0; in_side = '0; in_price = '0; in_qty = '0; in_stop = '0; in_trail = '0;
    idle(2);
    rst = 1'b0;
    check("rst_order_data", order_data, 32'h0);
    check("rst_in_ready", in_ready, 32'h1);
    idle(2);

    // Limit buy: stop and trail are dropped, strobe two edges after the handshake.
    hs = cyc + 1;
    send(2'b00, 2'b00, 8'h10, 8'h01, 8'h55, 4'd3);
    idle(6);
    check("limit_word", last_data, 32'h0100_1000);
    check("limit_latency", last_pulse_cyc, hs + 2);
    check("limit_sent", sent_count, 32'd1);

    send(2'b01, 2'b01, 8'h20, 8'h03, 8'h77, 4'd5);
    idle(8);
    check("market_word", last_data, 32'h5000_3000);

    // Back-to-back rejects: stop order with zero stop, then zero quantity.
    pb = n_pulses;
    send(2'b10, 2'b00, 8'h30, 8'h04, 8'h00, 4'd1);
    send(2'b00, 2'b01, 8'h30, 8'h00, 8'h00, 4'd0);
    check("reject_pulse_2nd", reject_pulse, 32'h1);
    idle(6);
    check("reject_count", reject_count, 32'd2);
    check("reject_no_pulse", n_pulses, pb);

    // Fill the buffer with the transmitter held off, then drain.
    enable = 1'b0;
    idle(3);
    for (int i = 0; i < DEPTH; i++) send_random_valid();
    check("full_in_ready", in_ready, 32'h0);
    in_type = 2'b00; in_side = 2'b00; in_qty = 8'h00; in_valid = 1'b1;
    idle(2);
    in_valid = 1'b0;
    check("full_no_reject", reject_count, 32'd2);
    pb = n_pulses;
    first = pulse_cyc.size();
    enable = 1'b1;
    tick();
    check("ready_after_pop", in_ready, 32'h1);
    idle(50);
    check("drain_pulses", n_pulses - pb, DEPTH);
    if (pulse_cyc.size() >= first + DEPTH)
      for (int i = 1; i < DEPTH; i++)
        check("drain_spacing", pulse_cyc[first+i] - pulse_cyc[first+i-1], GAP + 2);

    send(2'b11, 2'b00, 8'h50, 8'h05, 8'h60, 4'd2);
    idle(8);
    check("trail_word", last_data, 32'hC500_5602);

    // Random traffic with enable toggling and occasional invalid fields.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_type  = 2'($urandom);
      in_side  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      in_price = 8'($urandom);
      in_qty   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      in_stop  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      in_trail = 4'($urandom);
      enable   = ($urandom_range(0, 5) != 0);
      tick();
    end
    in_valid = 1'b0;
    enable = 1'b1;
    idle(60);

    // Reset while in a gap with three orders still buffered.
    pb = n_pulses;
    for (int i = 0; i < 4; i++) send_random_valid();
    check("pre_reset_pulse", n_pulses - pb, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pb = n_pulses;
    idle(20);
    check("post_reset_no_pulse", n_pulses, pb);
    check("post_reset_sent", sent_count, 32'd0);
    check("post_reset_ready", in_ready, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
